store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Receiving end of the retire stage's dword store interface (store_en / store2Dcache_addr / store2Dcache_data).
- Buffers committed stores in a FIFO and drains them one at a time to data memory over the BUS_STORE command / mem2proc_response protocol.
- Forwards buffered data to loads that hit a pending dword.
- Tells the pipeline when it is full, and when it is empty so halt can wait for the drain.

Parameters:
- SWB_DEPTH, 8, number of buffered dword stores; power of two, ≥2.
- SWB_IDX_W, $clog2(SWB_DEPTH), pointer width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- store_en  in  1  retire commits a store this cycle
- store_addr  in  `XLEN  dword-aligned address; bits [2:0] are ignored and treated as 0
- store_data  in  64  fully merged dword
- ld_lookup_addr  in  `XLEN  load address for forwarding (dword compare on [`XLEN-1:3])
- ld_fwd_hit  out  1  a buffered entry matches ld_lookup_addr
- ld_fwd_data  out  64  data of the youngest matching entry
- mem_bus_grant  in  1  arbiter gives this block the Dmem port this cycle
- mem2proc_response  in  4  nonzero means the request was accepted
- proc2Dmem_command  out  2  BUS_NONE / BUS_STORE
- proc2Dmem_addr  out  `XLEN  head entry address
- proc2Dmem_data  out  64  head entry data
- swb_full  out  1  count == SWB_DEPTH; retire must not assert store_en
- swb_empty  out  1  count == 0 and FSM in IDLE
- swb_count  out  SWB_IDX_W+1  occupancy

Behaviour:
- Storage: circular array of {valid, addr[`XLEN-1:3], data[63:0]} with head, tail and count registers; pointers wrap modulo SWB_DEPTH.
- Reset: all valid bits 0, head = tail = 0, count = 0, FSM = IDLE, command = BUS_NONE, addr = 0, data = 0, full = 0, empty = 1, ld_fwd_hit = 0, ld_fwd_data = 0.
- Push: on store_en, write at tail, tail++, count++, visible to forwarding the next cycle.
- Coalesce: if store_en's dword equals the youngest valid entry's dword and that entry is not the head in REQ, overwrite its data in place. No tail or count change.
- Push while swb_full with no same-cycle pop is illegal: assertion fires and the store is dropped. Push while full in a pop cycle is legal.
- The retire-side squash has no effect here; every entry is already committed.
- FSM IDLE: command = BUS_NONE. If count > 0, go to REQ next cycle.
- FSM REQ: command = BUS_STORE, addr/data = head entry; these stay stable while in REQ.
- Accept: mem_bus_grant && mem2proc_response != 0 pops the head (valid = 0, head++, count--). Go to IDLE if the post-pop count == 0, else stay in REQ and present the new head next cycle (one store per cycle max).
- Not granted, or response == 0: stay in REQ and retry. No timeout.
- Simultaneous push and pop: count unchanged; a push into a just-freed full slot is allowed.
- Forwarding is combinational: scan from tail-1 back to head and take the first valid match. Entries being pushed in the same cycle are not visible.
- swb_full, swb_empty and swb_count come from registered state, so they are glitch-free in the cycle after any change.
- Reset mid-REQ: an in-flight request is abandoned and command drops to BUS_NONE in the same cycle reset is sampled. Memory must tolerate this.

Decomposition:
- Shared package / sys_defs: SWB_DEPTH define, SWB_ENTRY packed struct {valid, addr, data}, SWB_STATE enum {SWB_IDLE, SWB_REQ}.
- BUS_NONE / BUS_STORE already exist there.
- One natural sub-module, swb_fwd_match: combinational youngest-match priority search over the entries given head/tail; outputs hit and index.

Test Plan:
- Reset, then idle 5 cycles -> command BUS_NONE, swb_empty = 1, swb_count = 0, ld_fwd_hit = 0.
- Push addr 0x100 data 0x1111_2222_3333_4444, grant = 1, response = 4'h3 -> next cycle IDLE→REQ with BUS_STORE addr 0x100 and that data; the cycle after, count = 0 and swb_empty = 1.
- Push 8 distinct dwords 0x0..0x38 with grant = 0 -> swb_full = 1, count = 8; a 9th store_en fires the assertion. Enable grant -> drains in order 0x0..0x38, one per cycle.
- Push 0x200 = A, then 0x208 = B, then 0x200 = C with grant = 0 -> count = 3 (0x200 is not youngest when C arrives). ld_lookup_addr 0x204 -> hit with data C.
- Push 0x300 = D, then 0x300 = E back-to-back with grant = 0 -> coalesced, count = 1, forwarded data E.
- Full buffer, grant = 1, response = 1, and store_en in the same cycle -> count stays 8 and the new entry lands in the freed slot. Then assert reset while in REQ -> command BUS_NONE, count = 0.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// ----------------------------------------------------------------------------
// store_write_buffer_pkg
// Shared definitions for the store write buffer slice. It holds the address
// width, the buffer depth, the Dmem bus command encodings, the buffer entry
// layout and the FSM state codes.
// ----------------------------------------------------------------------------
package store_write_buffer_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned SWB_DEPTH = 8;   // power of two, >= 2
   localparam int unsigned SWB_IDX_W = $clog2(SWB_DEPTH);

   // Dmem bus commands
   localparam logic [1:0] BUS_NONE  = 2'h0;
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;

   // FSM state codes
   localparam logic SWB_IDLE = 1'b0;
   localparam logic SWB_REQ  = 1'b1;

   // Only the dword part of the address is kept; bits [2:0] are implied zero.
   typedef struct packed {
      logic            valid;
      logic [XLEN-4:0] addr;
      logic [63:0]     data;
   } swb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// ----------------------------------------------------------------------------
// store_write_buffer_if
// Groups the retire-side store port, the load-forwarding port, the Dmem
// request/response port and the status outputs of the store write buffer.
//   slave  : the store write buffer itself
//   master : the pipeline / memory side that drives stores and grants
// ----------------------------------------------------------------------------
interface store_write_buffer_if;
   import store_write_buffer_pkg::*;

   logic                 store_en;
   logic [XLEN-1:0]      store_addr;
   logic [63:0]          store_data;
   logic [XLEN-1:0]      ld_lookup_addr;
   logic                 ld_fwd_hit;
   logic [63:0]          ld_fwd_data;
   logic                 mem_bus_grant;
   logic [3:0]           mem2proc_response;
   logic [1:0]           proc2Dmem_command;
   logic [XLEN-1:0]      proc2Dmem_addr;
   logic [63:0]          proc2Dmem_data;
   logic                 swb_full;
   logic                 swb_empty;
   logic [SWB_IDX_W:0]   swb_count;

   modport slave (
      input  store_en, store_addr, store_data, ld_lookup_addr,
      input  mem_bus_grant, mem2proc_response,
      output ld_fwd_hit, ld_fwd_data,
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output swb_full, swb_empty, swb_count
   );

   modport master (
      output store_en, store_addr, store_data, ld_lookup_addr,
      output mem_bus_grant, mem2proc_response,
      input  ld_fwd_hit, ld_fwd_data,
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  swb_full, swb_empty, swb_count
   );

endinterface

// File: rtl/store_write_buffer_fwd_match.sv
// ----------------------------------------------------------------------------
// store_write_buffer_fwd_match
// Combinational youngest-match search for store-to-load forwarding.
//   i_entries   : buffer storage
//   i_head      : index of the oldest entry
//   i_lookup_dw : load dword address (addr[XLEN-1:3])
//   o_hit       : some valid entry matches
//   o_idx       : index of the youngest matching entry
// ----------------------------------------------------------------------------
module store_write_buffer_fwd_match
   import store_write_buffer_pkg::*;
(
   input  swb_entry_t            i_entries [SWB_DEPTH],
   input  logic [SWB_IDX_W-1:0]  i_head,
   input  logic [XLEN-4:0]       i_lookup_dw,
   output logic                  o_hit,
   output logic [SWB_IDX_W-1:0]  o_idx
);

   // Valid bits are cleared on pop, so only live entries can match. Walking
   // from head in age order and letting later matches overwrite earlier ones
   // leaves the youngest match; the tail is not needed for that.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int k = 0; k < SWB_DEPTH; k++) begin
         if (i_entries[i_head + SWB_IDX_W'(k)].valid &&
             (i_entries[i_head + SWB_IDX_W'(k)].addr == i_lookup_dw)) begin
            o_hit = 1'b1;
            o_idx = i_head + SWB_IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/store_write_buffer.sv
// ----------------------------------------------------------------------------
// store_write_buffer
// Buffers committed dword stores from retire in a circular FIFO, drains them
// one at a time to data memory, and forwards buffered data to loads.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : store port, forwarding port, Dmem request/response,
//                  full/empty/count status
// ----------------------------------------------------------------------------
module store_write_buffer
   import store_write_buffer_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   store_write_buffer_if.slave  bus
);

   localparam logic [SWB_IDX_W:0] COUNT_FULL = (SWB_IDX_W+1)'(SWB_DEPTH);

   swb_entry_t            r_entries [SWB_DEPTH];
   logic [SWB_IDX_W-1:0]  r_head;
   logic [SWB_IDX_W-1:0]  r_tail;
   logic [SWB_IDX_W:0]    r_count;
   logic                  r_state;

   logic [SWB_IDX_W-1:0]  w_youngest;
   logic [XLEN-4:0]       w_store_dw;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_coalesce;
   logic                  w_push;
   logic                  w_req;
   logic [SWB_IDX_W:0]    w_count_d;
   logic                  w_state_d;
   logic                  w_fwd_hit;
   logic [SWB_IDX_W-1:0]  w_fwd_idx;
   logic                  w_unused_low_bits;

   assign w_store_dw = bus.store_addr[XLEN-1:3];
   assign w_full     = (r_count == COUNT_FULL);
   assign w_youngest = r_tail - SWB_IDX_W'(1);
   assign w_pop      = (r_state == SWB_REQ) && bus.mem_bus_grant &&
                       (bus.mem2proc_response != 4'h0);

   // Merge into the youngest entry unless it is the head currently on the bus,
   // whose address/data must stay stable until accepted.
   assign w_coalesce = bus.store_en && (r_count != '0) && r_entries[w_youngest].valid &&
                       (r_entries[w_youngest].addr == w_store_dw) &&
                       !((r_state == SWB_REQ) && (w_youngest == r_head));

   // A store arriving while full is only accepted if a slot frees this cycle.
   assign w_push = bus.store_en && !w_coalesce && (!w_full || w_pop);

   always_comb begin
      w_count_d = r_count;
      if (w_push && !w_pop) begin
         w_count_d = r_count + (SWB_IDX_W+1)'(1);
      end else if (w_pop && !w_push) begin
         w_count_d = r_count - (SWB_IDX_W+1)'(1);
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         SWB_IDLE: if (r_count != '0) w_state_d = SWB_REQ;
         SWB_REQ:  if (w_pop && (w_count_d == '0)) w_state_d = SWB_IDLE;
         default:  w_state_d = SWB_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SWB_DEPTH; i++) begin
            r_entries[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_state <= SWB_IDLE;
      end else begin
         // Clear before write: a push into a just-freed full slot must win.
         if (w_pop) begin
            r_entries[r_head].valid <= 1'b0;
            r_head                  <= r_head + SWB_IDX_W'(1);
         end
         if (w_push) begin
            r_entries[r_tail] <= '{valid: 1'b1, addr: w_store_dw, data: bus.store_data};
            r_tail            <= r_tail + SWB_IDX_W'(1);
         end
         if (w_coalesce) begin
            r_entries[w_youngest].data <= bus.store_data;
         end
         r_count <= w_count_d;
         r_state <= w_state_d;
      end
   end

   // Retire must never push into a full buffer without a same-cycle drain.
   a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
      !(bus.store_en && w_full && !w_pop && !w_coalesce));

   // Gating with reset drops an in-flight request in the cycle reset is seen.
   assign w_req                 = (r_state == SWB_REQ) && !reset;
   assign bus.proc2Dmem_command = w_req ? BUS_STORE : BUS_NONE;
   assign bus.proc2Dmem_addr    = w_req ? {r_entries[r_head].addr, 3'b000} : '0;
   assign bus.proc2Dmem_data    = w_req ? r_entries[r_head].data : '0;

   assign bus.swb_full  = w_full;
   assign bus.swb_empty = (r_count == '0) && (r_state == SWB_IDLE);
   assign bus.swb_count = r_count;

   store_write_buffer_fwd_match u_fwd_match (
      .i_entries   (r_entries),
      .i_head      (r_head),
      .i_lookup_dw (bus.ld_lookup_addr[XLEN-1:3]),
      .o_hit       (w_fwd_hit),
      .o_idx       (w_fwd_idx)
   );

   assign bus.ld_fwd_hit  = w_fwd_hit;
   assign bus.ld_fwd_data = w_fwd_hit ? r_entries[w_fwd_idx].data : '0;

   // Byte-offset bits are ignored by design.
   assign w_unused_low_bits = ^{bus.store_addr[2:0], bus.ld_lookup_addr[2:0]};

endmodule

// File: tb/tb_store_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_write_buffer
// Directed self-checking bench for store_write_buffer.
// ----------------------------------------------------------------------------
module tb_store_write_buffer;
   import store_write_buffer_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   store_write_buffer_if bus ();

   store_write_buffer u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] addr, input logic [63:0] data);
      bus.store_en   = 1'b1;
      bus.store_addr = addr;
      bus.store_data = data;
      tick();
      bus.store_en   = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset                 = 1'b1;
      bus.store_en          = 1'b0;
      bus.store_addr        = '0;
      bus.store_data        = '0;
      bus.ld_lookup_addr    = '0;
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      tick();
      tick();
      check("rst_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
      check("rst_count", 64'(bus.swb_count), 64'd0);
      check("rst_empty", 64'(bus.swb_empty), 64'd1);
      check("rst_full", 64'(bus.swb_full), 64'd0);
      reset = 1'b0;
      repeat (5) tick();
      check("idle_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
      check("idle_empty", 64'(bus.swb_empty), 64'd1);
      check("idle_count", 64'(bus.swb_count), 64'd0);
      check("idle_hit", 64'(bus.ld_fwd_hit), 64'd0);
      check("idle_fdata", bus.ld_fwd_data, 64'd0);

      // Single store, granted immediately.
      bus.mem_bus_grant     = 1'b1;
      bus.mem2proc_response = 4'h3;
      bus.ld_lookup_addr    = 32'h100;
      push(32'h100, 64'h1111_2222_3333_4444);
      check("one_count", 64'(bus.swb_count), 64'd1);
      check("one_cmd_idle", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
      check("one_hit", 64'(bus.ld_fwd_hit), 64'd1);
      check("one_fdata", bus.ld_fwd_data, 64'h1111_2222_3333_4444);
      tick();
      check("one_cmd_req", 64'(bus.proc2Dmem_command), 64'(BUS_STORE));
      check("one_addr", 64'(bus.proc2Dmem_addr), 64'h100);
      check("one_data", bus.proc2Dmem_data, 64'h1111_2222_3333_4444);
      tick();
      check("one_done_count", 64'(bus.swb_count), 64'd0);
      check("one_done_empty", 64'(bus.swb_empty), 64'd1);
      check("one_done_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
      check("one_done_hit", 64'(bus.ld_fwd_hit), 64'd0);

      // Fill to full with no grant, then drain in order.
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      for (int i = 0; i < 8; i++) push(32'(i * 8), 64'hA0 + 64'(i));
      check("fill_full", 64'(bus.swb_full), 64'd1);
      check("fill_count", 64'(bus.swb_count), 64'd8);
      check("fill_empty", 64'(bus.swb_empty), 64'd0);
      tick();
      check("retry_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_STORE));
      check("retry_addr", 64'(bus.proc2Dmem_addr), 64'h0);
      bus.mem_bus_grant = 1'b1;
      check("ungrant_resp0_addr", 64'(bus.proc2Dmem_addr), 64'h0);
      tick();
      check("resp0_count", 64'(bus.swb_count), 64'd8);
      bus.mem2proc_response = 4'h1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_addr%0d", i), 64'(bus.proc2Dmem_addr), 64'(i * 8));
         check($sformatf("drain_data%0d", i), bus.proc2Dmem_data, 64'hA0 + 64'(i));
         check($sformatf("drain_count%0d", i), 64'(bus.swb_count), 64'(8 - i));
         tick();
      end
      check("drain_empty", 64'(bus.swb_empty), 64'd1);
      check("drain_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));

      // Non-youngest duplicate is not coalesced; forwarding picks youngest.
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      push(32'h200, 64'hAAAA);
      push(32'h208, 64'hBBBB);
      push(32'h200, 64'hCCCC);
      check("dup_count", 64'(bus.swb_count), 64'd3);
      bus.ld_lookup_addr = 32'h204;
      #1;
      check("dup_hit", 64'(bus.ld_fwd_hit), 64'd1);
      check("dup_fdata", bus.ld_fwd_data, 64'hCCCC);
      bus.ld_lookup_addr = 32'h208;
      #1;
      check("dup_fdata_b", bus.ld_fwd_data, 64'hBBBB);
      bus.ld_lookup_addr = 32'h210;
      #1;
      check("dup_miss", 64'(bus.ld_fwd_hit), 64'd0);
      check("dup_head_data", bus.proc2Dmem_data, 64'hAAAA);
      bus.mem_bus_grant     = 1'b1;
      bus.mem2proc_response = 4'h1;
      repeat (3) tick();
      check("dup_drained", 64'(bus.swb_empty), 64'd1);

      // Back-to-back same dword coalesces while the head is not on the bus.
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      bus.ld_lookup_addr    = 32'h300;
      push(32'h300, 64'hDDDD);
      push(32'h300, 64'hEEEE);
      check("coal_count", 64'(bus.swb_count), 64'd1);
      check("coal_fdata", bus.ld_fwd_data, 64'hEEEE);
      check("coal_bus_data", bus.proc2Dmem_data, 64'hEEEE);
      // Head is now on the bus: same dword must take a new slot.
      push(32'h300, 64'hFFFF);
      check("nocoal_count", 64'(bus.swb_count), 64'd2);
      check("nocoal_fdata", bus.ld_fwd_data, 64'hFFFF);
      check("nocoal_bus_data", bus.proc2Dmem_data, 64'hEEEE);
      bus.mem_bus_grant     = 1'b1;
      bus.mem2proc_response = 4'h1;
      tick();
      check("nocoal_next_data", bus.proc2Dmem_data, 64'hFFFF);
      tick();
      check("nocoal_empty", 64'(bus.swb_empty), 64'd1);

      // Push into a freed slot while full, then reset mid-request.
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      for (int i = 0; i < 8; i++) push(32'h400 + 32'(i * 8), 64'hB0 + 64'(i));
      tick();
      check("pp_full", 64'(bus.swb_full), 64'd1);
      bus.mem_bus_grant     = 1'b1;
      bus.mem2proc_response = 4'h1;
      push(32'h480, 64'hC0);
      bus.mem_bus_grant     = 1'b0;
      bus.mem2proc_response = 4'h0;
      check("pp_count", 64'(bus.swb_count), 64'd8);
      check("pp_full2", 64'(bus.swb_full), 64'd1);
      check("pp_head", 64'(bus.proc2Dmem_addr), 64'h408);
      bus.ld_lookup_addr = 32'h480;
      #1;
      check("pp_new_hit", 64'(bus.ld_fwd_hit), 64'd1);
      check("pp_new_data", bus.ld_fwd_data, 64'hC0);
      bus.ld_lookup_addr = 32'h400;
      #1;
      check("pp_popped_miss", 64'(bus.ld_fwd_hit), 64'd0);
      reset = 1'b1;
      #1;
      check("rreq_cmd", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
      tick();
      check("rreq_count", 64'(bus.swb_count), 64'd0);
      check("rreq_empty", 64'(bus.swb_empty), 64'd1);
      check("rreq_full", 64'(bus.swb_full), 64'd0);
      bus.ld_lookup_addr = 32'h480;
      #1;
      check("rreq_hit", 64'(bus.ld_fwd_hit), 64'd0);
      reset = 1'b0;
      tick();
      check("rreq_cmd2", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
